ahb_bus_arbiter: RTL

- Multi-master arbiter for the AHB interconnect.
- Shares the single address/data path among NUM_MASTERS masters and decides which master owns the bus.
- Drives h_grant to the masters, and h_master/h_mastlock to the address mux, decoder and slaves, including the default slave.
- Rearbitrates only at legal burst boundaries. Honours locked sequences. Parks the bus on a default master when no master requests.

---
 rtl/ahb_bus_arbiter_if.sv | 26 ++
 rtl/ahb_bus_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: arbitration bundle between the AHB masters and the arbiter.
//   master : the requesting side (bus masters / address-phase owner).
//   slave  : the arbiter's view (takes requests, drives grant and ownership).
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MASTER_ID_W = 2
);
  logic [NUM_MASTERS-1:0] h_busreq;
  logic [NUM_MASTERS-1:0] h_lock;
  logic [1:0]             h_trans;
  logic [2:0]             h_burst;
  logic                   h_ready;
  logic [NUM_MASTERS-1:0] h_grant;
  logic [MASTER_ID_W-1:0] h_master;
  logic                   h_mastlock;

  modport master (
    output h_busreq, h_lock, h_trans, h_burst, h_ready,
    input  h_grant, h_master, h_mastlock
  );

  modport slave (
    input  h_busreq, h_lock, h_trans, h_burst, h_ready,
    output h_grant, h_master, h_mastlock
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: multi-master AHB arbiter.
//   - Registered one-hot grant, rearbitrated only at burst boundaries.
//   - Locked owner keeps the bus while it still requests.
//   - Parks on DEFAULT_MASTER when nobody requests.
//   - h_master/h_mastlock trail the grant by one accepted cycle.
// Build option: define ARB_FIXED_PRIORITY_EN to replace round-robin with
// lowest-index-wins fixed priority.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MASTER_ID_W    = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic              h_clk,
  input  logic              h_resetn,
  ahb_bus_arbiter_if.slave  bus
);
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;

  localparam logic [MASTER_ID_W-1:0] DEF_ID    = MASTER_ID_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MASTER_ID_W-1:0] master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [MASTER_ID_W-1:0] last_q, last_d;

  logic [MASTER_ID_W-1:0] owner;
  logic [4:0]             blen;
  logic                   rearb;
  logic [MASTER_ID_W-1:0] pick;
  logic                   found;

  // Encode the one-hot grant into the current owner index.
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) owner = MASTER_ID_W'(i);
  end

  // Fixed burst length; zero for SINGLE and undefined-length INCR.
  always_comb begin
    case (bus.h_burst)
      3'd2, 3'd3: blen = 5'd4;
      3'd4, 3'd5: blen = 5'd8;
      3'd6, 3'd7: blen = 5'd16;
      default:    blen = 5'd0;
    endcase
  end

  // Beat counter: loaded on a fixed-length NONSEQ, counts down on SEQ.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.h_ready) begin
      if (bus.h_trans == TR_NONSEQ && blen != 5'd0)
        cnt_d = blen - 5'd1;
      else if (bus.h_trans == TR_SEQ && cnt_q != 5'd0)
        cnt_d = cnt_q - 5'd1;
    end
  end

  // Legal handover points; BUSY and stalled cycles never qualify.
  always_comb begin
    rearb = bus.h_ready &
            ((bus.h_trans == TR_IDLE) |
             (bus.h_trans == TR_NONSEQ && bus.h_burst == BU_SINGLE) |
             (bus.h_trans == TR_SEQ && cnt_q == 5'd1) |
             (bus.h_burst == BU_INCR && bus.h_trans[1] && !bus.h_busreq[owner]));
  end

  // Candidate selection among current requesters.
  always_comb begin
    pick  = DEF_ID;
    found = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (bus.h_busreq[i]) begin
        pick  = MASTER_ID_W'(i);
        found = 1'b1;
      end
`else
    // Scan upward from the slot after last_owner; last_owner itself is checked last.
    for (int i = 1; i <= NUM_MASTERS; i++)
      if (!found && bus.h_busreq[(int'(last_q) + i) % NUM_MASTERS]) begin
        pick  = MASTER_ID_W'((int'(last_q) + i) % NUM_MASTERS);
        found = 1'b1;
      end
`endif
  end

  // Next grant: lock keeps owner, else chosen requester, else park on default.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (rearb) begin
      if (bus.h_lock[owner] && bus.h_busreq[owner]) begin
        grant_d = grant_q;
      end else if (found) begin
        grant_d = NUM_MASTERS'(1) << pick;
        last_d  = pick;
      end else begin
        grant_d = DEF_GRANT;
      end
    end
  end

  // Address-phase ownership follows the pre-edge grant on each accepted cycle.
  always_comb begin
    master_d   = master_q;
    mastlock_d = mastlock_q;
    if (bus.h_ready) begin
      master_d   = owner;
      mastlock_d = bus.h_lock[owner];
    end
  end

  // State registers; async reset clears any in-flight burst.
  always_ff @(posedge h_clk or negedge h_resetn) begin
    if (!h_resetn) begin
      grant_q    <= DEF_GRANT;
      master_q   <= DEF_ID;
      mastlock_q <= 1'b0;
      cnt_q      <= 5'd0;
      last_q     <= DEF_ID;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign bus.h_grant    = grant_q;
  assign bus.h_master   = master_q;
  assign bus.h_mastlock = mastlock_q;
endmodule
